// File: rtl/fetch_if.sv
// Fetch-side bundle: backend redirect/hold, I-cache request/response and
// instruction-queue enqueue, seen from the fetch controller (master).
interface fetch_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        iq_full;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        iq_push;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic [31:0] fetch_pc;

    modport master (
        input  redirect_valid, redirect_pc, stall, iq_full, imem_rdata, imem_resp,
        output imem_addr, imem_rmask, iq_push, iq_inst, iq_pc, fetch_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, stall, iq_full, imem_rdata, imem_resp,
        input  imem_addr, imem_rmask, iq_push, iq_inst, iq_pc, fetch_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch controller: issues one I-cache read at a
// time, forwards the response to the instruction queue, and squashes on redirect.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_q, pc_next;
    logic [31:0] issued_pc_q;
    logic        issue, push;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pc_next    = pc_q;
        issue      = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.redirect_valid) begin
                    pc_next = bus.redirect_pc;
                end else if (!bus.stall && !bus.iq_full) begin
                    issue      = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.redirect_valid) begin
                    // A response in the same cycle is stale and simply dropped.
                    pc_next    = bus.redirect_pc;
                    state_next = bus.imem_resp ? IDLE : SQUASH;
                end else if (bus.imem_resp) begin
                    push       = 1'b1;
                    pc_next    = pc_q + 32'd4;
                    state_next = IDLE;
                end
            end
            SQUASH: begin
                if (bus.redirect_valid) begin
                    pc_next = bus.redirect_pc;
                end
                if (bus.imem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            // A request already in flight must still have its response eaten.
            if ((state == WAIT || state == SQUASH) && !bus.imem_resp) begin
                state <= SQUASH;
            end else begin
                state <= IDLE;
            end
        end else begin
            state <= state_next;
            pc_q  <= pc_next;
        end
    end

    // NOTE: the issued PC is pure datapath, only read while a request is in
    // flight, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && issue) begin
            issued_pc_q <= pc_q;
        end
    end

    assign bus.imem_rmask = (!rst && issue) ? 4'b1111 : 4'b0000;
    assign bus.imem_addr  = rst ? 32'd0 : ((state == IDLE) ? pc_q : issued_pc_q);
    assign bus.iq_push    = !rst && push;
    assign bus.iq_inst    = (!rst && push) ? bus.imem_rdata : 32'd0;
    assign bus.iq_pc      = (!rst && push) ? issued_pc_q : 32'd0;
    assign bus.fetch_pc   = pc_q;

endmodule
